// File: rtl/rand_pos_gen.sv
// ---------------------------------------------------------------------------
// rand_pos_gen
//
// This module picks a free food cell on the snake grid.
//
// A free-running xorshift register advances on every clock edge. When the
// game-control FSM sends a request, a rejection-sampling FSM reads (x,y)
// candidates from the low bits of that register. It throws away candidates
// that fall outside the grid. It sends each in-grid candidate to the body
// occupancy checker and waits for an answer. It returns the first free cell,
// or reports failure once MAX_TRIES draws have been rejected.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   seed_load  : load seed_in into the xorshift state this cycle
//   seed_in    : seed value (zero is replaced by SEED_DEFAULT)
//   rand_out   : current xorshift state
//   req        : request a new position (sampled only while idle)
//   busy       : high while a request is being served
//   occ_req    : occupancy query valid
//   occ_x/y    : queried cell, stable until occ_ack
//   occ_ack    : occupancy answer strobe
//   occ_hit    : queried cell is occupied (valid with occ_ack)
//   pos_valid  : result available
//   pos_ready  : consumer accepts result
//   pos_x/y    : resulting free cell (0 when pos_fail)
//   pos_fail   : all draws rejected, no position found
// ---------------------------------------------------------------------------
module rand_pos_gen #(
  parameter int               WIDTH        = 16,
  parameter int               SH_A         = 7,
  parameter int               SH_B         = 9,
  parameter int               SH_C         = 8,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(16'hACE1),
  parameter int               GRID_W       = 20,
  parameter int               GRID_H       = 15,
  parameter int               MAX_TRIES    = 16,
  localparam int              X_BITS       = $clog2(GRID_W),
  localparam int              Y_BITS       = $clog2(GRID_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed_in,
  output logic [WIDTH-1:0]  rand_out,
  input  logic              req,
  output logic              busy,
  output logic              occ_req,
  output logic [X_BITS-1:0] occ_x,
  output logic [Y_BITS-1:0] occ_y,
  input  logic              occ_ack,
  input  logic              occ_hit,
  output logic              pos_valid,
  input  logic              pos_ready,
  output logic [X_BITS-1:0] pos_x,
  output logic [Y_BITS-1:0] pos_y,
  output logic              pos_fail
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  // Grid limits are one bit wider than the candidate fields. This keeps a
  // full power-of-two grid (for example GRID_W = 32) from wrapping to zero.
  localparam logic [X_BITS:0]  X_LIM    = (X_BITS+1)'(GRID_W);
  localparam logic [Y_BITS:0]  Y_LIM    = (Y_BITS+1)'(GRID_H);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  // Configuration checks, evaluated at elaboration.
  generate
    if (X_BITS + Y_BITS > WIDTH) begin : g_width_chk
      $error("rand_pos_gen: X_BITS+Y_BITS exceeds WIDTH");
    end
    if (SEED_DEFAULT == '0) begin : g_seed_chk
      $error("rand_pos_gen: SEED_DEFAULT must be nonzero");
    end
    if (MAX_TRIES < 1) begin : g_tries_chk
      $error("rand_pos_gen: MAX_TRIES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_QUERY = 2'd2,
    S_DONE  = 2'd3
  } fsm_t;

  // One xorshift step. All shifts are logical and truncated to WIDTH.
  // A nonzero input never produces a zero output.
  function automatic logic [WIDTH-1:0] xorshift_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s ^ (s << SH_A);
    t = t ^ (t >> SH_B);
    t = t ^ (t << SH_C);
    return t;
  endfunction

  logic [WIDTH-1:0]  state_q,    state_d;
  fsm_t              fsm_q,      fsm_d;
  logic [TRY_W-1:0]  try_cnt_q,  try_cnt_d;
  logic [X_BITS-1:0] occ_x_q,    occ_x_d;
  logic [Y_BITS-1:0] occ_y_q,    occ_y_d;
  logic [X_BITS-1:0] pos_x_q,    pos_x_d;
  logic [Y_BITS-1:0] pos_y_q,    pos_y_d;
  logic              pos_fail_q, pos_fail_d;

  logic [X_BITS-1:0] cand_x;
  logic [Y_BITS-1:0] cand_y;
  logic              cand_in_grid;
  logic              reject;

  // The state register ignores the FSM. Reseeding may happen at any time
  // without disturbing a request in progress.
  always_comb begin
    state_d = xorshift_step(state_q);
    if (seed_load) begin
      state_d = (seed_in == '0) ? SEED_DEFAULT : seed_in;
    end
  end

  assign cand_x       = state_q[X_BITS-1:0];
  assign cand_y       = state_q[X_BITS+Y_BITS-1:X_BITS];
  assign cand_in_grid = ({1'b0, cand_x} < X_LIM) && ({1'b0, cand_y} < Y_LIM);

  always_comb begin
    fsm_d      = fsm_q;
    try_cnt_d  = try_cnt_q;
    occ_x_d    = occ_x_q;
    occ_y_d    = occ_y_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    pos_fail_d = pos_fail_q;
    reject     = 1'b0;

    case (fsm_q)
      S_IDLE: begin
        if (req) begin
          fsm_d     = S_DRAW;
          try_cnt_d = '0;
        end
      end

      S_DRAW: begin
        if (cand_in_grid) begin
          occ_x_d = cand_x;
          occ_y_d = cand_y;
          fsm_d   = S_QUERY;
        end else begin
          reject = 1'b1;
        end
      end

      S_QUERY: begin
        if (occ_ack) begin
          if (!occ_hit) begin
            pos_x_d    = occ_x_q;
            pos_y_d    = occ_y_q;
            pos_fail_d = 1'b0;
            fsm_d      = S_DONE;
          end else begin
            reject = 1'b1;
          end
        end
      end

      S_DONE: begin
        // A req seen here or in the accept cycle is dropped. The requester
        // must still be asserting it once we are back in idle.
        if (pos_ready) begin
          fsm_d = S_IDLE;
        end
      end

      default: fsm_d = S_IDLE;
    endcase

    // Out-of-grid and occupied candidates use the same draw budget.
    if (reject) begin
      if (try_cnt_q == TRY_LAST) begin
        fsm_d      = S_DONE;
        pos_fail_d = 1'b1;
        pos_x_d    = '0;
        pos_y_d    = '0;
      end else begin
        try_cnt_d = try_cnt_q + 1'b1;
        fsm_d     = S_DRAW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEED_DEFAULT;
      fsm_q      <= S_IDLE;
      try_cnt_q  <= '0;
      occ_x_q    <= '0;
      occ_y_q    <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      pos_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fsm_q      <= fsm_d;
      try_cnt_q  <= try_cnt_d;
      occ_x_q    <= occ_x_d;
      occ_y_q    <= occ_y_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      pos_fail_q <= pos_fail_d;
    end
  end

  assign rand_out  = state_q;
  assign busy      = (fsm_q != S_IDLE);
  assign occ_req   = (fsm_q == S_QUERY);
  assign occ_x     = occ_x_q;
  assign occ_y     = occ_y_q;
  assign pos_valid = (fsm_q == S_DONE);
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign pos_fail  = pos_fail_q;

endmodule
